clk_rst_manager: RTL and testbench
==================================

CLK_RST_MANAGER -- requirements
Module: clk_rst_manager

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 16, divisor width per channel.
REQ-003 SHALL have parameter PLL_RST_CYC, default 16, cycles PLL_RESETB held low per attempt.
REQ-004 SHALL have parameter LOCK_WAIT, default 1024, cycles allowed for lock before retry.
REQ-005 SHALL have parameter RST_HOLD, default 64, cycles of stable lock before SYS_RESET release.
REQ-006 SHALL have parameter MAX_RETRY, default 3, failed attempts tolerated before FAULT.
REQ-007 SHALL have port REFERENCECLK  input  1  sole clock; all logic rising-edge.
REQ-008 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port PLL_LOCK  input  1  raw PLL LOCK, asynchronous to REFERENCECLK.
REQ-010 SHALL have port DIV  input  NUM_CH*DIV_W  channel divisors, channel i at bits [i*DIV_W +: DIV_W].
REQ-011 SHALL have port CH_EN  input  NUM_CH  per-channel enable.
REQ-012 SHALL have port PLL_RESETB  output  1  active-low PLL reset.
REQ-013 SHALL have port SYS_RESET  output  1  active-high downstream reset.
REQ-014 SHALL have port LOCKED_OK  output  1  high only in RUN.
REQ-015 SHALL have port FAULT  output  1  sticky lock failure flag.
REQ-016 SHALL have port RETRY_CNT  output  3  failed attempts since RESET, saturating at 7.
REQ-017 SHALL have port CE  output  NUM_CH  one-cycle clock-enable strobes.

Function
REQ-018 SHALL pass PLL_LOCK through a 2-flop synchronizer; "lock" below means synchronized value (2-cycle latency).
REQ-019 SHALL implement states PLL_RST, WAIT_LOCK, HOLD, RUN, FAULT with one shared cycle counter.
REQ-020 PLL_RST: PLL_RESETB=0; after PLL_RST_CYC cycles -> WAIT_LOCK, counter cleared.
REQ-021 WAIT_LOCK: PLL_RESETB=1; lock=1 -> HOLD; counter reaching LOCK_WAIT with lock=0 -> RETRY_CNT+1, then PLL_RST, or FAULT if incremented count exceeds MAX_RETRY.
REQ-022 HOLD: lock=0 at any cycle -> WAIT_LOCK with counter cleared (no retry charged); RST_HOLD consecutive lock cycles -> RUN.
REQ-023 RUN: SYS_RESET=0, LOCKED_OK=1; lock=0 -> PLL_RST, RETRY_CNT+1, SYS_RESET asserted same cycle as state change (next edge after sync sees 0).
REQ-024 FAULT: terminal until RESET; PLL_RESETB=0, SYS_RESET=1, FAULT=1, CE=0.
REQ-025 SYS_RESET SHALL be 1 in every state except RUN.
REQ-026 Each channel SHALL hold a DIV_W-bit counter, active only in RUN with CH_EN[i]=1, else cleared to 0 and CE[i]=0.
REQ-027 Active channel: CE[i]=1 for one cycle when counter == DIV[i]-1, counter then wraps to 0; otherwise counter+1.
REQ-028 DIV[i]=0 or 1 SHALL give CE[i]=1 every active cycle.
REQ-029 DIV[i] SHALL be sampled into a shadow register at each wrap and at activation; mid-period changes take effect next period.
REQ-030 First CE[i] after activation SHALL occur DIV[i] cycles after the first active cycle (DIV>=2).
REQ-031 CE outputs SHALL be registered; no combinational path from inputs to any output.

Reset
REQ-032 RESET=1 SHALL asynchronously force: state PLL_RST, counters 0, synchronizer 0, PLL_RESETB=0, SYS_RESET=1, LOCKED_OK=0, FAULT=0, RETRY_CNT=0, CE=0.
REQ-033 RESET deassertion SHALL start a fresh sequence from PLL_RST regardless of prior state, including FAULT.
REQ-034 RESET asserted mid-RUN SHALL drop all CE and LOCKED_OK immediately, without waiting for a clock edge.

Verification
REQ-035 Params 4/3/8/2: release RESET, PLL_LOCK=1 at cycle 10 -> PLL_RESETB rises cycle 4, SYS_RESET falls 8 cycles after synced lock, LOCKED_OK=1.
REQ-036 PLL_LOCK held 0, MAX_RETRY=2 -> RETRY_CNT 1,2,3 then FAULT=1, PLL_RESETB=0, persists until RESET.
REQ-037 RUN, DIV ch0=5, ch1=1, ch2=0 -> CE0 every 5th cycle, CE1/CE2 every cycle; CH_EN[3]=0 -> CE3 never.
REQ-038 RUN, drop PLL_LOCK one cycle -> SYS_RESET=1, CE=0, RETRY_CNT=1, re-sequence to RUN.
REQ-039 Lock glitch low during HOLD -> return to WAIT_LOCK, RETRY_CNT unchanged, hold count restarts.
REQ-040 Change DIV ch0 5->3 mid-period -> current period completes at 5, following periods 3.

Source files
------------

// File: rtl/clk_rst_manager.sv
// PLL reset/lock sequencer with downstream reset control and per-channel clock-enable dividers.
// All logic runs on REFERENCECLK; RESET is asynchronous and active-high.
module clk_rst_manager #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 16,
   parameter int PLL_RST_CYC = 16,
   parameter int LOCK_WAIT   = 1024,
   parameter int RST_HOLD    = 64,
   parameter int MAX_RETRY   = 3
) (
   input  logic                    REFERENCECLK,
   input  logic                    RESET,
   input  logic                    PLL_LOCK,
   input  logic [NUM_CH*DIV_W-1:0] DIV,
   input  logic [NUM_CH-1:0]       CH_EN,
   output logic                    PLL_RESETB,
   output logic                    SYS_RESET,
   output logic                    LOCKED_OK,
   output logic                    FAULT,
   output logic [2:0]              RETRY_CNT,
   output logic [NUM_CH-1:0]       CE
);

   localparam int CMAX = (LOCK_WAIT > PLL_RST_CYC) ?
                         ((LOCK_WAIT > RST_HOLD) ? LOCK_WAIT : RST_HOLD) :
                         ((PLL_RST_CYC > RST_HOLD) ? PLL_RST_CYC : RST_HOLD);
   localparam int CW = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_HOLD      = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   logic          lock_meta_q, lock_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    retry_q, retry_d, retry_sat_s;
   logic          retry_over_s;
   logic          pll_resetb_q, sys_reset_q, locked_ok_q, fault_q;

   assign retry_sat_s  = (retry_q == 3'd7) ? 3'd7 : (retry_q + 3'd1);
   assign retry_over_s = ({29'd0, retry_q} + 32'd1) > 32'(MAX_RETRY);

   // Two-flop synchronizer for the asynchronous PLL lock indication
   always_ff @(posedge REFERENCECLK or posedge RESET) begin
      if (RESET) begin
         lock_meta_q <= 1'b0;
         lock_q      <= 1'b0;
      end else begin
         lock_meta_q <= PLL_LOCK;
         lock_q      <= lock_meta_q;
      end
   end

   // Sequencer next state, shared cycle counter and retry accounting
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      case (state_q)
         S_PLL_RST: begin
            if (cnt_q == CW'(PLL_RST_CYC - 1)) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (lock_q) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else if (cnt_q == CW'(LOCK_WAIT - 1)) begin
               retry_d = retry_sat_s;
               cnt_d   = '0;
               state_d = retry_over_s ? S_FAULT : S_PLL_RST;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            // A lock drop while holding is a glitch, not a failed attempt
            if (!lock_q) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CW'(RST_HOLD - 1)) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            if (!lock_q) begin
               state_d = S_PLL_RST;
               cnt_d   = '0;
               retry_d = retry_sat_s;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer state and registered status outputs derived from the next state
   always_ff @(posedge REFERENCECLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_PLL_RST;
         cnt_q        <= '0;
         retry_q      <= 3'd0;
         pll_resetb_q <= 1'b0;
         sys_reset_q  <= 1'b1;
         locked_ok_q  <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         pll_resetb_q <= (state_d == S_WAIT_LOCK) || (state_d == S_HOLD) || (state_d == S_RUN);
         sys_reset_q  <= (state_d != S_RUN);
         locked_ok_q  <= (state_d == S_RUN);
         fault_q      <= (state_d == S_FAULT);
      end
   end

   assign PLL_RESETB = pll_resetb_q;
   assign SYS_RESET  = sys_reset_q;
   assign LOCKED_OK  = locked_ok_q;
   assign FAULT      = fault_q;
   assign RETRY_CNT  = retry_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] ch_cnt_q, shad_q;
      logic [DIV_W-1:0] div_live_s, div_eff_s;
      logic             act_q, ce_q, active_s, wrap_s;

      // Channels gate on the next state so CE never outlives LOCKED_OK
      assign active_s   = (state_d == S_RUN) && CH_EN[i];
      assign div_live_s = DIV[i*DIV_W +: DIV_W];
      assign div_eff_s  = act_q ? shad_q : div_live_s;
      assign wrap_s     = (div_eff_s <= DIV_W'(1)) || (ch_cnt_q == (div_eff_s - DIV_W'(1)));

      // Divider counter, period shadow and strobe for one channel
      always_ff @(posedge REFERENCECLK or posedge RESET) begin
         if (RESET) begin
            ch_cnt_q <= '0;
            shad_q   <= '0;
            act_q    <= 1'b0;
            ce_q     <= 1'b0;
         end else if (active_s) begin
            act_q <= 1'b1;
            if (wrap_s) begin
               ce_q     <= 1'b1;
               ch_cnt_q <= '0;
               shad_q   <= div_live_s;
            end else begin
               ce_q     <= 1'b0;
               ch_cnt_q <= ch_cnt_q + DIV_W'(1);
               shad_q   <= div_eff_s;
            end
         end else begin
            act_q    <= 1'b0;
            ce_q     <= 1'b0;
            ch_cnt_q <= '0;
            shad_q   <= shad_q;
         end
      end

      assign CE[i] = ce_q;
   end

endmodule

// File: tb/tb_clk_rst_manager.sv
// Directed bench for clk_rst_manager: expectations are queued ahead of each step and popped as outputs are sampled.
module tb_clk_rst_manager;
   localparam int NCH = 4;
   localparam int DW  = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             pll_lock;
   logic [NCH*DW-1:0] div;
   logic [NCH-1:0]   ch_en;
   logic             pll_resetb, sys_reset, locked_ok, fault;
   logic [2:0]       retry_cnt;
   logic [NCH-1:0]   ce;

   clk_rst_manager #(
      .NUM_CH(NCH), .DIV_W(DW), .PLL_RST_CYC(4), .LOCK_WAIT(3), .RST_HOLD(8), .MAX_RETRY(2)
   ) dut (
      .REFERENCECLK(clk),
      .RESET       (rst),
      .PLL_LOCK    (pll_lock),
      .DIV         (div),
      .CH_EN       (ch_en),
      .PLL_RESETB  (pll_resetb),
      .SYS_RESET   (sys_reset),
      .LOCKED_OK   (locked_ok),
      .FAULT       (fault),
      .RETRY_CNT   (retry_cnt),
      .CE          (ce)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic at(input int e);
      while (cyc < e) tick();
   endtask

   task automatic expect_v(input string t, input logic [31:0] v);
      sb_q.push_back('{t, v});
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t it;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: got %0h, nothing expected", obs);
      end else begin
         it = sb_q.pop_front();
         assert (obs === it.val) else begin
            n_err++;
            $error("FAIL %s: got %0h required %0h", it.tag, obs, it.val);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      pll_lock = 1'b1;
      div      = {8'd4, 8'd0, 8'd1, 8'd5};
      ch_en    = 4'b0111;
      tick();
      tick();

      // Reset state
      expect_v("rst_pllrb", 32'd0);
      expect_v("rst_sysrst", 32'd1);
      expect_v("rst_locked", 32'd0);
      expect_v("rst_fault", 32'd0);
      expect_v("rst_retry", 32'd0);
      expect_v("rst_ce", 32'd0);
      check(pll_resetb); check(sys_reset); check(locked_ok);
      check(fault); check(retry_cnt); check(ce);

      // Bring-up with lock present from the start
      rst = 1'b0;
      cyc = 0;
      expect_v("pllrb_c3", 32'd0);  at(3);  check(pll_resetb);
      expect_v("pllrb_c4", 32'd1);  at(4);  check(pll_resetb);
      expect_v("sysrst_c12", 32'd1); at(12); check(sys_reset);
      expect_v("sysrst_c13", 32'd0);
      expect_v("locked_c13", 32'd1);
      at(13); check(sys_reset); check(locked_ok);

      // CE pattern; ch0 divisor changes 5->3 just after cycle 23
      for (int e = 13; e <= 33; e++)
         expect_v($sformatf("ce_c%0d", e),
                  {28'd0, 1'b0, 1'b1, 1'b1, (e == 17 || e == 22 || e == 27 || e == 30 || e == 33)});
      for (int e = 13; e <= 33; e++) begin
         at(e);
         check(ce);
         if (e == 23) div[7:0] = 8'd3;
      end

      // One-cycle lock drop in RUN
      at(34); pll_lock = 1'b0;
      at(35); pll_lock = 1'b1;
      expect_v("drop_locked_c36", 32'd1); at(36); check(locked_ok);
      expect_v("drop_sysrst_c37", 32'd1);
      expect_v("drop_locked_c37", 32'd0);
      expect_v("drop_ce_c37", 32'd0);
      expect_v("drop_retry_c37", 32'd1);
      at(37); check(sys_reset); check(locked_ok); check(ce); check(retry_cnt);
      expect_v("drop_sysrst_c49", 32'd1); at(49); check(sys_reset);
      expect_v("rerun_sysrst_c50", 32'd0);
      expect_v("rerun_locked_c50", 32'd1);
      expect_v("rerun_retry_c50", 32'd1);
      expect_v("rerun_ce_c50", 32'b0110);
      at(50); check(sys_reset); check(locked_ok); check(retry_cnt); check(ce);

      // Asynchronous reset mid-RUN clears outputs without a clock edge
      at(52);
      rst = 1'b1;
      #1;
      expect_v("async_ce", 32'd0);
      expect_v("async_locked", 32'd0);
      expect_v("async_sysrst", 32'd1);
      check(ce); check(locked_ok); check(sys_reset);
      tick();
      rst = 1'b0;
      cyc = 0;

      // Lock glitch during HOLD
      at(6); pll_lock = 1'b0;
      at(7); pll_lock = 1'b1;
      expect_v("glitch_sysrst_c9", 32'd1);
      expect_v("glitch_pllrb_c9", 32'd1);
      expect_v("glitch_retry_c9", 32'd0);
      at(9); check(sys_reset); check(pll_resetb); check(retry_cnt);
      expect_v("glitch_sysrst_c13", 32'd1); at(13); check(sys_reset);
      expect_v("glitch_sysrst_c17", 32'd1); at(17); check(sys_reset);
      expect_v("glitch_sysrst_c18", 32'd0);
      expect_v("glitch_retry_c18", 32'd0);
      at(18); check(sys_reset); check(retry_cnt);

      // No lock at all: retries then sticky FAULT
      pll_lock = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0;
      expect_v("nolock_retry_c6", 32'd0); at(6); check(retry_cnt);
      expect_v("nolock_retry_c7", 32'd1);
      expect_v("nolock_pllrb_c7", 32'd0);
      at(7); check(retry_cnt); check(pll_resetb);
      expect_v("nolock_retry_c14", 32'd2); at(14); check(retry_cnt);
      expect_v("nolock_fault_c20", 32'd0);
      expect_v("nolock_retry_c20", 32'd2);
      at(20); check(fault); check(retry_cnt);
      expect_v("fault_retry_c21", 32'd3);
      expect_v("fault_flag_c21", 32'd1);
      expect_v("fault_pllrb_c21", 32'd0);
      expect_v("fault_sysrst_c21", 32'd1);
      at(21); check(retry_cnt); check(fault); check(pll_resetb); check(sys_reset);
      pll_lock = 1'b1;
      expect_v("fault_sticky", 32'd1);
      expect_v("fault_sticky_retry", 32'd3);
      expect_v("fault_locked", 32'd0);
      expect_v("fault_ce", 32'd0);
      at(51); check(fault); check(retry_cnt); check(locked_ok); check(ce);

      // RESET clears FAULT and restarts the sequence
      rst = 1'b1;
      #1;
      expect_v("clr_fault", 32'd0);
      expect_v("clr_retry", 32'd0);
      check(fault); check(retry_cnt);
      tick();
      rst = 1'b0;
      cyc = 0;
      expect_v("restart_locked_c13", 32'd1);
      expect_v("restart_fault_c13", 32'd0);
      at(13); check(locked_ok); check(fault);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
